// File: rtl/vn_if.sv
// Handshake and data bundle for the variable-node unit.
//   master : upstream/downstream side (drives inputs, out_ready)
//   slave  : vn_unit side (drives in_ready and the result beat)
// Signals: in_valid/in_ready + llr_in, c2v_1..3 on the input side;
//          out_valid/out_ready + v2c_1..3, hard_bit, sat_flag on the output side.
interface vn_if #(parameter int W = 16);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] llr_in;
  logic [W-1:0] c2v_1, c2v_2, c2v_3;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] v2c_1, v2c_2, v2c_3;
  logic         hard_bit;
  logic         sat_flag;

  modport master (
    output in_valid, llr_in, c2v_1, c2v_2, c2v_3, out_ready,
    input  in_ready, out_valid, v2c_1, v2c_2, v2c_3, hard_bit, sat_flag
  );

  modport slave (
    input  in_valid, llr_in, c2v_1, c2v_2, c2v_3, out_ready,
    output in_ready, out_valid, v2c_1, v2c_2, v2c_3, hard_bit, sat_flag
  );
endinterface

// File: rtl/vn_unit.sv
// Pipelined min-sum LDPC variable-node processor (degree 3).
// Per beat: total = llr + c2v_1 + c2v_2 + c2v_3, v2c_k = sat(total - c2v_k),
// hard_bit = sign(total), sat_flag = any v2c clamped.
// Ports: clk, rst_n (async active-low), io (vn_if.slave) carrying the
// in_valid/in_ready input beat and out_valid/out_ready result beat.
// Two stages: S1 holds total + c2v, S2 holds the saturated results.

// One extrinsic edge: subtract own message, clamp to the symmetric range so
// the check node can always negate the result.
module vn_lane #(
  parameter int W = 16
) (
  input  logic signed [W+1:0] total,
  input  logic        [W-1:0] c2v,
  output logic        [W-1:0] v2c,
  output logic                sat
);
  localparam logic signed [W+2:0] MAXV = {4'b0000, {(W-1){1'b1}}};
  localparam logic signed [W+2:0] MINV = -MAXV;

  logic signed [W+2:0] diff;

  assign diff = $signed({total[W+1], total}) - $signed({{3{c2v[W-1]}}, c2v});

  always_comb begin
    v2c = diff[W-1:0];
    sat = 1'b0;
    if (diff > MAXV) begin
      v2c = MAXV[W-1:0];
      sat = 1'b1;
    end else if (diff < MINV) begin
      v2c = MINV[W-1:0];
      sat = 1'b1;
    end
  end
endmodule

module vn_unit #(
  parameter int INT  = 8,
  parameter int FRAC = 8,
  parameter int DV   = 3
) (
  input logic clk,
  input logic rst_n,
  vn_if.slave io
);
  localparam int W  = INT + FRAC;
  localparam int TW = W + 2;

  // vld_pipe[1] = S1 valid, vld_pipe[2] = S2 valid (== out_valid)
  logic [2:1] vld_pipe;
  logic       s1_adv, s2_adv, accept;

  assign s2_adv      = !vld_pipe[2] || io.out_ready;
  assign s1_adv      = !vld_pipe[1] || s2_adv;
  assign io.in_ready = s1_adv;
  assign accept      = io.in_valid && s1_adv;

  // ---- stage 1: sum of all incoming messages ----
  logic [DV-1:0][W-1:0] c2v_in;
  logic signed [TW-1:0] total_d;

  assign c2v_in  = {io.c2v_3, io.c2v_2, io.c2v_1};
  assign total_d = $signed({{2{io.llr_in[W-1]}}, io.llr_in})
                 + $signed({{2{io.c2v_1[W-1]}},  io.c2v_1})
                 + $signed({{2{io.c2v_2[W-1]}},  io.c2v_2})
                 + $signed({{2{io.c2v_3[W-1]}},  io.c2v_3});

  logic signed [TW-1:0] s1_total;
  logic [DV-1:0][W-1:0] s1_c2v;

  // S1 data is qualified by vld_pipe[1], so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_total <= total_d;
      s1_c2v   <= c2v_in;
    end
  end

  // ---- per-edge extrinsic + saturation ----
  logic [DV-1:0][W-1:0] v2c_d;
  logic [DV-1:0]        sat_d;

  for (genvar k = 0; k < DV; k++) begin : g_lane
    vn_lane #(.W(W)) u_lane (
      .total (s1_total),
      .c2v   (s1_c2v[k]),
      .v2c   (v2c_d[k]),
      .sat   (sat_d[k])
    );
  end

  // ---- stage 2: output registers (reset, held while stalled) ----
  logic [DV-1:0][W-1:0] s2_v2c;
  logic                 s2_hard, s2_sat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s2_v2c   <= '0;
      s2_hard  <= 1'b0;
      s2_sat   <= 1'b0;
    end else begin
      if (s1_adv) vld_pipe[1] <= io.in_valid;
      if (s2_adv) vld_pipe[2] <= vld_pipe[1];
      if (s2_adv && vld_pipe[1]) begin
        s2_v2c  <= v2c_d;
        s2_hard <= s1_total[TW-1];
        s2_sat  <= |sat_d;
      end
    end
  end

  assign io.out_valid = vld_pipe[2];
  assign io.v2c_1     = s2_v2c[0];
  assign io.v2c_2     = s2_v2c[1];
  assign io.v2c_3     = s2_v2c[2];
  assign io.hard_bit  = s2_hard;
  assign io.sat_flag  = s2_sat;
endmodule

// File: tb/tb_vn_unit.sv
// Directed bench for vn_unit: reset, arithmetic corners, backpressure,
// back-to-back throughput and mid-stream reset.
module tb_vn_unit;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vn_if #(.W(W)) bus ();

  vn_unit #(.INT(8), .FRAC(8), .DV(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic idle_inputs();
    bus.in_valid  = 1'b0;
    bus.llr_in    = '0;
    bus.c2v_1     = '0;
    bus.c2v_2     = '0;
    bus.c2v_3     = '0;
    bus.out_ready = 1'b1;
  endtask

  // Present one beat, wait for its result (bounded); stimulus only.
  task automatic drive_beat(input logic [W-1:0] llr, c1, c2, c3,
                            output int lat, output logic [3*W+1:0] res);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.llr_in = llr;
    bus.c2v_1 = c1; bus.c2v_2 = c2; bus.c2v_3 = c3;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat = 99;
    res = '0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        lat = i;
        res = {bus.v2c_1, bus.v2c_2, bus.v2c_3, bus.hard_bit, bus.sat_flag};
        break;
      end
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #12;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if ({bus.v2c_1, bus.v2c_2, bus.v2c_3} !== 48'h0) begin n_err++; $display("FAIL rst_v2c: got %h want 0", {bus.v2c_1, bus.v2c_2, bus.v2c_3}); end
    n_cmp++; if ({bus.hard_bit, bus.sat_flag} !== 2'b00) begin n_err++; $display("FAIL rst_flags: got %b want 00", {bus.hard_bit, bus.sat_flag}); end
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk); #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_basic();
    int lat; logic [3*W+1:0] r;
    drive_beat(16'h0100, 16'h0080, 16'hFF80, 16'h0200, lat, r);
    n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL basic_latency: got %0d want 2", lat); end
    n_cmp++; if (r[3*W+1:2] !== {16'h0280, 16'h0380, 16'h0100}) begin n_err++; $display("FAIL basic_v2c: got %h want 028003800100", r[3*W+1:2]); end
    n_cmp++; if (r[1:0] !== 2'b00) begin n_err++; $display("FAIL basic_flags: got %b want 00", r[1:0]); end
  endtask

  task automatic test_pos_sat();
    int lat; logic [3*W+1:0] r;
    drive_beat(16'h7F00, 16'h7F00, 16'h7F00, 16'h0000, lat, r);
    n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL possat_latency: got %0d want 2", lat); end
    n_cmp++; if (r[3*W+1:2] !== {16'h7FFF, 16'h7FFF, 16'h7FFF}) begin n_err++; $display("FAIL possat_v2c: got %h want 7fff7fff7fff", r[3*W+1:2]); end
    n_cmp++; if (r[1:0] !== 2'b01) begin n_err++; $display("FAIL possat_flags: got %b want 01", r[1:0]); end
  endtask

  task automatic test_neg_clamp();
    int lat; logic [3*W+1:0] r;
    drive_beat(16'h8000, 16'hFF00, 16'h0000, 16'h0000, lat, r);
    n_cmp++; if (r[3*W+1:2] !== {16'h8001, 16'h8001, 16'h8001}) begin n_err++; $display("FAIL negsat_v2c: got %h want 800180018001", r[3*W+1:2]); end
    n_cmp++; if (r[1:0] !== 2'b11) begin n_err++; $display("FAIL negsat_flags: got %b want 11", r[1:0]); end
    drive_beat(16'hFE00, 16'h0000, 16'h0000, 16'h0000, lat, r);
    n_cmp++; if (r[3*W+1:2] !== {16'hFE00, 16'hFE00, 16'hFE00}) begin n_err++; $display("FAIL neg_v2c: got %h want fe00fe00fe00", r[3*W+1:2]); end
    n_cmp++; if (r[1:0] !== 2'b10) begin n_err++; $display("FAIL neg_flags: got %b want 10", r[1:0]); end
  endtask

  // Beat k: llr=(k+1)*0x100, c2v_1=(k+1)*0x10, c2v_2=0, c2v_3=8.
  task automatic test_backpressure();
    int sent = 0, got = 0;
    logic [3*W+1:0] hold, cur, exp;
    for (int c = 0; c < 40 && got < 6; c++) begin
      @(negedge clk);
      bus.out_ready = !(c >= 3 && c <= 5);
      bus.in_valid  = (sent < 6);
      bus.llr_in    = 16'((sent + 1) * 16'h0100);
      bus.c2v_1     = 16'((sent + 1) * 16'h0010);
      bus.c2v_2     = 16'h0000;
      bus.c2v_3     = 16'h0008;
      #1;
      cur = {bus.v2c_1, bus.v2c_2, bus.v2c_3, bus.hard_bit, bus.sat_flag};
      if (c >= 3 && c <= 5) begin
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready c%0d: got %b want 0", c, bus.in_ready); end
      end
      if (c == 3) hold = cur;
      if (c == 4 || c == 5) begin
        n_cmp++; if (!bus.out_valid || cur !== hold) begin n_err++; $display("FAIL bp_stable c%0d: got %b/%h want 1/%h", c, bus.out_valid, cur, hold); end
      end
      if (bus.out_valid && bus.out_ready) begin
        exp = {16'((got + 1) * 16'h0100 + 8), 16'((got + 1) * 16'h0110 + 8),
               16'((got + 1) * 16'h0110), 2'b00};
        n_cmp++; if (cur !== exp) begin n_err++; $display("FAIL bp_beat%0d: got %h want %h", got, cur, exp); end
        got++;
      end
      if (bus.in_valid && bus.in_ready) sent++;
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    n_cmp++; if (got !== 6 || sent !== 6) begin n_err++; $display("FAIL bp_count: got %0d/%0d want 6/6", got, sent); end
    @(negedge clk); #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL bp_no_dup: got %b want 0", bus.out_valid); end
  endtask

  // Beat k: llr = k*0x100 - 0x500, c2v_1 = 0x40, others 0.
  task automatic test_back_to_back();
    int sent = 0, got = 0, first = -1;
    int l;
    logic [3*W+1:0] cur, exp;
    for (int c = 0; c < 40 && got < 10; c++) begin
      @(negedge clk);
      bus.out_ready = 1'b1;
      bus.in_valid  = (sent < 10);
      l             = sent * 256 - 1280;
      bus.llr_in    = l[15:0];
      bus.c2v_1     = 16'h0040;
      bus.c2v_2     = 16'h0000;
      bus.c2v_3     = 16'h0000;
      #1;
      if (bus.in_valid && bus.in_ready && sent == 0) first = c;
      if (bus.out_valid) begin
        n_cmp++; if (c !== first + 2 + got) begin n_err++; $display("FAIL bt_cycle%0d: got %0d want %0d", got, c, first + 2 + got); end
        l   = got * 256 - 1280;
        exp = {l[15:0], 16'(l + 64), 16'(l + 64), (l + 64 < 0), 1'b0};
        cur = {bus.v2c_1, bus.v2c_2, bus.v2c_3, bus.hard_bit, bus.sat_flag};
        n_cmp++; if (cur !== exp) begin n_err++; $display("FAIL bt_beat%0d: got %h want %h", got, cur, exp); end
        got++;
      end
      if (bus.in_valid && bus.in_ready) sent++;
    end
    bus.in_valid = 1'b0;
    n_cmp++; if (got !== 10) begin n_err++; $display("FAIL bt_count: got %0d want 10", got); end
  endtask

  task automatic test_reset_midstream();
    logic stale = 1'b0;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.llr_in = 16'h8000;
    bus.c2v_1 = 16'hFF00; bus.c2v_2 = 16'h0000; bus.c2v_3 = 16'h0000;
    @(negedge clk);
    bus.llr_in = 16'h0300;
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    n_cmp++; if ({bus.out_valid, bus.hard_bit, bus.sat_flag} !== 3'b111) begin n_err++; $display("FAIL mid_preload: got %b want 111", {bus.out_valid, bus.hard_bit, bus.sat_flag}); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL mid_out_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if ({bus.v2c_1, bus.v2c_2, bus.v2c_3, bus.hard_bit, bus.sat_flag} !== 50'h0) begin n_err++; $display("FAIL mid_outputs: got %h want 0", {bus.v2c_1, bus.v2c_2, bus.v2c_3, bus.hard_bit, bus.sat_flag}); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL mid_in_ready: got %b want 1", bus.in_ready); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      if (bus.out_valid) stale = 1'b1;
    end
    n_cmp++; if (stale !== 1'b0) begin n_err++; $display("FAIL mid_stale: got %b want 0", stale); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pos_sat();
    test_neg_clamp();
    test_backpressure();
    test_back_to_back();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
